// File: rtl/four_bank_mem_pkg.sv
// Shared address-field layout for four_bank_mem and mem_system_fsm.
// Both sides decode bank and row from the byte address with these constants.
package four_bank_mem_pkg;
  localparam int ADDR_W    = 16;
  localparam int WORD_W    = 16;
  localparam int BANK_W    = 2;
  localparam int NUM_BANKS = 1 << BANK_W;
  localparam int BANK_LSB  = 1;
  localparam int ROW_LSB   = BANK_LSB + BANK_W;
endpackage

// File: rtl/dff.sv
// Generic enabled flop with synchronous active-high reset.
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mem_bank.sv
// One interleaved bank: row array, occupancy down-counter and registered read port.
module mem_bank
  import four_bank_mem_pkg::*;
#(
  parameter int ROW_W    = 13,
  parameter int BUSY_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic              we,
  input  logic [ROW_W-1:0]  wrow,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ROW_W-1:0]  rrow,
  output logic              busy,
  output logic [WORD_W-1:0] rdata
);
  localparam int CNT_W = $clog2(BUSY_CYC + 1);

  logic [WORD_W-1:0] mem [2**ROW_W];
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [WORD_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[wrow] <= wdata;
  end

  always_comb begin
    cnt_d = cnt;
    if (acc)             cnt_d = CNT_W'(BUSY_CYC);
    else if (cnt != '0)  cnt_d = cnt - CNT_W'(1);
  end

  dff #(.W(CNT_W)) u_cnt (.clk(clk), .rst(rst), .en(1'b1), .d(cnt_d), .q(cnt));

  assign busy = (cnt != '0);

  // A write landing on the same edge as the read must still be observed.
  assign rdata_d = (we && (wrow == rrow)) ? wdata : mem[rrow];

  dff #(.W(WORD_W)) u_rdata (.clk(clk), .rst(rst), .en(re), .d(rdata_d), .q(rdata));
endmodule

// File: rtl/four_bank_mem.sv
// Four-way word-interleaved memory: bank decode, accept/stall/err, read pipe, output mux.
// Handshake: a request (rd^wr) is taken on the edge where stall=0; while stall=1 the requester holds addr/data/rd/wr.
module four_bank_mem
  import four_bank_mem_pkg::*;
#(
  parameter int ROW_W    = 13,
  parameter int BUSY_CYC = 4,
  parameter int READ_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WORD_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [WORD_W-1:0]    data_out,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);
  localparam int ENT_W  = 1 + BANK_W + ROW_W;
  localparam int TAIL_W = 1 + BANK_W;

  logic [BANK_W-1:0] bank;
  logic [ROW_W-1:0]  row;
  logic              req;
  logic              malformed;
  logic              accept;
  logic [ENT_W-1:0]  ent_in;
  logic [ENT_W-1:0]  issue;
  logic [TAIL_W-1:0] tail;
  logic [WORD_W-1:0] bank_rdata [NUM_BANKS];

  assign bank      = addr[BANK_LSB +: BANK_W];
  assign row       = addr[ROW_LSB +: ROW_W];
  assign req       = rd ^ wr;
  assign malformed = (rd & wr) | ((rd | wr) & addr[0]);
  assign accept    = req & ~addr[0] & ~busy[bank];
  assign stall     = req & ~addr[0] & busy[bank];
  assign ent_in    = {accept & rd, bank, row};

  dff #(.W(1)) u_err (.clk(clk), .rst(rst), .en(1'b1), .d(malformed), .q(err));

  // The issue point is one cycle before return: banks read there, the tail picks the bank.
  generate
    if (READ_LAT == 1) begin : g_lat1
      assign issue = ent_in;
    end else begin : g_pipe
      logic [ENT_W-1:0] stage [READ_LAT-1];
      for (genvar i = 0; i < READ_LAT - 1; i++) begin : g_st
        if (i == 0) begin : g_first
          dff #(.W(ENT_W)) u_st (.clk(clk), .rst(rst), .en(1'b1), .d(ent_in), .q(stage[i]));
        end else begin : g_next
          dff #(.W(ENT_W)) u_st (.clk(clk), .rst(rst), .en(1'b1), .d(stage[i-1]), .q(stage[i]));
        end
      end
      assign issue = stage[READ_LAT-2];
    end
  endgenerate

  dff #(.W(TAIL_W)) u_tail (
    .clk(clk), .rst(rst), .en(1'b1), .d(issue[ENT_W-1 -: TAIL_W]), .q(tail)
  );

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(.ROW_W(ROW_W), .BUSY_CYC(BUSY_CYC)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .acc   (accept && (bank == BANK_W'(b))),
      .we    (accept && wr && (bank == BANK_W'(b))),
      .wrow  (row),
      .wdata (data_in),
      .re    (issue[ENT_W-1] && (issue[ROW_W +: BANK_W] == BANK_W'(b))),
      .rrow  (issue[ROW_W-1:0]),
      .busy  (busy[b]),
      .rdata (bank_rdata[b])
    );
  end

  always_comb begin
    data_out = '0;
    if (tail[TAIL_W-1]) data_out = bank_rdata[tail[BANK_W-1:0]];
  end
endmodule

// File: tb/tb_four_bank_mem.sv
// Directed bench for four_bank_mem with a per-cycle reference model and read-data scoreboard.
module tb_four_bank_mem;
  localparam int BUSY_CYC = 4;
  localparam int READ_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  always #5 clk = ~clk;

  four_bank_mem #(.ROW_W(13), .BUSY_CYC(BUSY_CYC), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
    .data_out(data_out), .stall(stall), .busy(busy), .err(err)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  int          ret_q[$];
  int          mcnt[4];
  logic        merr = 1'b0;
  logic [15:0] mmem[int];
  logic        last_acc = 1'b0;
  logic        last_stall = 1'b0;
  bit          checking = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic       mreq, mmal, macc, mstall;
    logic [3:0] mbusy;
    int         b;
    b      = int'(addr[2:1]);
    mreq   = rd ^ wr;
    mmal   = (rd & wr) | ((rd | wr) & addr[0]);
    macc   = mreq & ~addr[0] & (mcnt[b] == 0);
    mstall = mreq & ~addr[0] & (mcnt[b] != 0);
    @(negedge clk);
    if (checking) begin
      for (int i = 0; i < 4; i++) mbusy[i] = (mcnt[i] != 0);
      check("busy", 32'(busy), 32'(mbusy));
      check("stall", 32'(stall), 32'(mstall));
      check("err", 32'(err), 32'(merr));
      if (ret_q.size() > 0 && ret_q[0] == cyc) begin
        void'(ret_q.pop_front());
        check("rdata", 32'(data_out), 32'(exp_q.pop_front()));
      end else begin
        check("data_idle", 32'(data_out), 32'h0);
      end
    end
    last_acc   = macc & ~rst;
    last_stall = mstall;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
      merr = 1'b0;
      exp_q.delete();
      ret_q.delete();
    end else begin
      merr = mmal;
      for (int i = 0; i < 4; i++) begin
        if (macc && i == b)    mcnt[i] = BUSY_CYC;
        else if (mcnt[i] != 0) mcnt[i] = mcnt[i] - 1;
      end
      if (macc && wr) mmem[int'(addr)] = data_in;
      if (macc && rd) begin
        exp_q.push_back(mmem[int'(addr)]);
        ret_q.push_back(cyc + READ_LAT);
      end
    end
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    rd = 1'b0;
    wr = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present a request and hold it until the model says it was taken.
  task automatic do_req(logic r, logic w, logic [15:0] a, logic [15:0] d, output int stalls);
    int n;
    n = 0;
    stalls = 0;
    rd = r; wr = w; addr = a; data_in = d;
    do begin
      cycle();
      if (last_stall) stalls++;
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      vectors++;
      miscompares++;
      $error("FAIL req_timeout observed=not_accepted expected=accepted addr=%0h", a);
    end
    rd = 1'b0;
    wr = 1'b0;
  endtask

  initial begin
    int          s;
    logic [15:0] a;
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
    cycle();
    cycle();
    rst = 1'b0;
    checking = 1'b1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);

    // Single write, bank 0 busy for BUSY_CYC cycles
    do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, s);
    check("t1_stall", 32'(s), 32'h0);
    for (int k = 0; k < BUSY_CYC; k++) begin
      check("t1_busy", 32'(busy), 32'h1);
      cycle();
    end
    check("t1_busy_clear", 32'(busy), 32'h0);

    // Read back
    do_req(1'b1, 1'b0, 16'h0010, 16'h0, s);
    idle(READ_LAT + 2);

    // Fill banks 0..3, then read them back-to-back
    for (int k = 0; k < 4; k++) begin
      a = 16'h0020 + 16'(2 * k);
      do_req(1'b0, 1'b1, a, 16'($urandom_range(0, 16'hFFFF)), s);
      check("t3_wr_stall", 32'(s), 32'h0);
    end
    idle(BUSY_CYC);
    for (int k = 0; k < 4; k++) begin
      a = 16'h0020 + 16'(2 * k);
      do_req(1'b1, 1'b0, a, 16'h0, s);
      check("t3_rd_stall", 32'(s), 32'h0);
    end
    check("t3_busy_peak", 32'(busy), 32'hF);
    idle(BUSY_CYC + READ_LAT);

    // Same-bank back-to-back reads
    do_req(1'b0, 1'b1, 16'h0000, 16'h1234, s);
    do_req(1'b0, 1'b1, 16'h0008, 16'h5678, s);
    idle(BUSY_CYC);
    do_req(1'b1, 1'b0, 16'h0000, 16'h0, s);
    do_req(1'b1, 1'b0, 16'h0008, 16'h0, s);
    check("t4_stalls", 32'(s), 32'(BUSY_CYC));
    idle(BUSY_CYC + READ_LAT);

    // Malformed requests
    rd = 1'b1; wr = 1'b1; addr = 16'h0010;
    cycle();
    rd = 1'b0; wr = 1'b0;
    check("t5_err_both", 32'(err), 32'h1);
    check("t5_busy_both", 32'(busy), 32'h0);
    cycle();
    rd = 1'b1; addr = 16'h0001;
    cycle();
    rd = 1'b0;
    check("t5_err_odd", 32'(err), 32'h1);
    check("t5_busy_odd", 32'(busy), 32'h0);
    idle(READ_LAT + 2);

    // Reset one cycle after a read accept drops the read
    do_req(1'b1, 1'b0, 16'h0010, 16'h0, s);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_busy", 32'(busy), 32'h0);
    idle(READ_LAT + 2);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0, s);
    idle(READ_LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
